// File: rtl/fxp_div_arbiter.sv
// Shared signed fixed-point divider: round-robin grant among NCH requesters,
// one restoring quotient bit per cycle, saturated quotient tagged with channel.
module fxp_div_arbiter #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int NCH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH*W-1:0]         req_dividend,
    input  logic [NCH*W-1:0]         req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NCH)-1:0]   rsp_ch,
    output logic [W-1:0]             rsp_quotient,
    output logic                     rsp_dbz,
    output logic                     rsp_ovf,
    output logic                     busy
);
    localparam int CW   = $clog2(NCH);
    localparam int NW   = W + FRAC;
    localparam int CNTW = $clog2(NW + 1);
    localparam logic [CW:0]   NCH_L  = (CW+1)'(NCH);
    localparam logic [W-1:0]  QMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  QMIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [NW-1:0] QPOS_L = NW'(QMAX);
    localparam logic [NW-1:0] QNEG_L = NW'(QMIN);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_RESP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   r_ch;
    logic [CNTW-1:0] r_cnt;
    logic            r_rsp_valid;
    logic [CW-1:0]   r_rsp_ch;
    logic [W-1:0]    r_rsp_q;
    logic            r_rsp_dbz;
    logic            r_rsp_ovf;

    logic [NW-1:0]   r_num;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_den;
    logic            r_neg;
    logic            r_dvd_neg;

    logic [NCH-1:0]      w_gnt;
    logic [CW-1:0]       w_gidx;
    logic                w_found;
    logic [CW:0]         w_idx;
    logic                w_acc;
    logic signed [W-1:0] w_dvd;
    logic signed [W-1:0] w_dsr;
    logic [W:0]          w_trial;
    logic [W-1:0]        w_diff;
    logic                w_qbit;
    logic [W+1:0]        w_fix;

    // The most negative operand maps to magnitude 2^(W-1) without wrapping.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
        return x[W-1] ? W'(-x) : W'(x);
    endfunction

    // Returns {dbz, ovf, quotient}: sign applied with truncation toward zero, then clamped.
    function automatic logic [W+1:0] saturate(input logic [NW-1:0] qm, input logic neg,
                                              input logic dbz, input logic dvd_neg);
        logic [W-1:0] q;
        logic         ovf;
        q   = qm[W-1:0];
        ovf = 1'b0;
        if (dbz) begin
            q = dvd_neg ? QMIN : QMAX;
        end else if (!neg) begin
            if (qm > QPOS_L) begin
                q   = QMAX;
                ovf = 1'b1;
            end
        end else if (qm > QNEG_L) begin
            q   = QMIN;
            ovf = 1'b1;
        end else begin
            q = ~qm[W-1:0] + W'(1);
        end
        return {dbz, ovf, q};
    endfunction

    always_comb begin
        w_gnt   = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_idx >= NCH_L) w_idx = w_idx - NCH_L;
            if (!w_found && req_valid[w_idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_idx[CW-1:0];
            end
        end
        if (w_found) w_gnt[w_gidx] = 1'b1;
    end

    always_comb begin
        w_dvd = '0;
        w_dsr = '0;
        for (int j = 0; j < NCH; j++) begin
            if (w_gidx == CW'(j)) begin
                w_dvd = req_dividend[j*W +: W];
                w_dsr = req_divisor[j*W +: W];
            end
        end
    end

    assign w_acc     = (r_state == S_IDLE) && w_found;
    assign req_ready = (r_state == S_IDLE && rst_n) ? w_gnt : '0;

    assign w_trial = {r_rem, r_num[NW-1]};
    assign w_qbit  = (w_trial >= {1'b0, r_den});
    assign w_diff  = w_trial[W-1:0] - r_den;
    assign w_fix   = saturate(r_num, r_neg, (r_den == '0), r_dvd_neg);

    // Datapath: operand load on accept, then the quotient shifts into r_num LSB-first.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_num     <= NW'(magnitude(w_dvd)) << FRAC;
            r_rem     <= '0;
            r_den     <= magnitude(w_dsr);
            r_neg     <= w_dvd[W-1] ^ w_dsr[W-1];
            r_dvd_neg <= w_dvd[W-1];
        end else if (r_state == S_DIV) begin
            r_rem <= w_qbit ? w_diff : w_trial[W-1:0];
            r_num <= {r_num[NW-2:0], w_qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_ch    <= '0;
            r_rsp_q     <= '0;
            r_rsp_dbz   <= 1'b0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_ch    <= w_gidx;
                        r_ptr   <= (w_gidx == CW'(NCH-1)) ? '0 : w_gidx + 1'b1;
                        r_cnt   <= CNTW'(NW-1);
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_rsp_dbz   <= w_fix[W+1];
                    r_rsp_ovf   <= w_fix[W];
                    r_rsp_q     <= w_fix[W-1:0];
                    r_rsp_ch    <= r_ch;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_ch       = r_rsp_ch;
    assign rsp_quotient = r_rsp_q;
    assign rsp_dbz      = r_rsp_dbz;
    assign rsp_ovf      = r_rsp_ovf;
    assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_fxp_div_arbiter.sv
// Scoreboard bench for fxp_div_arbiter: directed vectors with hand-computed quotients,
// latency, fairness, backpressure and mid-division reset.
module tb_fxp_div_arbiter;
    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int LAT  = 50;
    localparam int NTV  = 13;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*W-1:0]  req_dividend;
    logic [NCH*W-1:0]  req_divisor;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CW-1:0]     rsp_ch;
    logic [W-1:0]      rsp_quotient;
    logic              rsp_dbz;
    logic              rsp_ovf;
    logic              busy;

    fxp_div_arbiter #(.W(W), .FRAC(FRAC), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_quotient(rsp_quotient), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [W-1:0]  q;
        logic          dbz;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [W-1:0] tv_dvd [NTV] = '{32'h00030000, 32'hFFFE8000, 32'h00010000, 32'hFFFF0000,
                                   32'h7FFF0000, 32'h80000000, 32'h80000000, 32'hFFFB0000,
                                   32'h00000000, 32'h00020000, 32'h00000000, 32'hFFFF0000,
                                   32'h7FFFFFFF};
    logic [W-1:0] tv_dsr [NTV] = '{32'h00020000, 32'h00008000, 32'h00030000, 32'h00030000,
                                   32'h00000001, 32'h00010000, 32'hFFFF0000, 32'h00000000,
                                   32'h00000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFD0000,
                                   32'h7FFFFFFF};
    logic [W-1:0] tv_q   [NTV] = '{32'h00018000, 32'hFFFD0000, 32'h00005555, 32'hFFFFAAAB,
                                   32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                                   32'h7FFFFFFF, 32'hFFFE0000, 32'h00000000, 32'h00005555,
                                   32'h00010000};
    logic         tv_dbz [NTV] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic         tv_ovf [NTV] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic chk_rst();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_ch", rsp_ch, 0);
        chk("rst_rsp_quotient", rsp_quotient, 0);
        chk("rst_rsp_dbz", rsp_dbz, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic post(input int ch, input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                        input logic [W-1:0] q, input logic dbz, input logic ovf);
        exp_t e;
        req_dividend[ch*W +: W] = dvd;
        req_divisor[ch*W +: W]  = dsr;
        req_valid[ch]           = 1'b1;
        e.ch  = CW'(ch);
        e.q   = q;
        e.dbz = dbz;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic wait_grants(input int n);
        int got = 0;
        logic [NCH-1:0] taken;
        for (int b = 0; b < 600 && got < n; b++) begin
            @(negedge clk);
            taken = req_valid & req_ready;
            if (taken != '0) begin
                acc_q.push_back(cyc + 1);
                got++;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~taken;
        end
        if (got < n) fail("grant_timeout");
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((exp_q.size() != 0 || busy) && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b >= 3000) fail("idle_timeout");
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        logic prev_v;
        exp_t prev;
        exp_t e;
        int   a;
        prev_v = 1'b0;
        prev   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (busy) chk("ready_while_busy", req_ready, 0);
                chk("ready_onehot0", $onehot0(req_ready), 1);
                if (rsp_valid && !prev_v) begin
                    if (acc_q.size() == 0) chk("stray_rsp_valid", rsp_valid, 0);
                    else begin
                        a = acc_q.pop_front();
                        chk("latency", cyc + 1 - a, LAT);
                    end
                end
                if (rsp_valid && prev_v)
                    chk("stall_stable", {rsp_ch, rsp_quotient, rsp_dbz, rsp_ovf}, prev);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_ch", rsp_ch, e.ch);
                        chk("rsp_quotient", rsp_quotient, e.q);
                        chk("rsp_dbz", rsp_dbz, e.dbz);
                        chk("rsp_ovf", rsp_ovf, e.ovf);
                    end
                end
                prev_v = rsp_valid;
                prev   = {rsp_ch, rsp_quotient, rsp_dbz, rsp_ovf};
            end
        end
    end

    initial begin
        int hs;
        int stray;
        logic [W-1:0] v;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rst();
        rst_n = 1'b1;

        // All channels pending together straight out of reset.
        for (int k = 0; k < NCH; k++) begin
            v = W'((k + 1) << 16);
            post(k, v, 32'h00010000, v, 1'b0, 1'b0);
        end
        wait_grants(NCH);
        wait_idle();

        post(0, 32'h00050000, 32'h00020000, 32'h00028000, 1'b0, 1'b0);
        post(2, 32'hFFF60000, 32'h00040000, 32'hFFFD8000, 1'b0, 1'b0);
        wait_grants(2);
        wait_idle();

        for (int i = 0; i < NTV; i++) begin
            post((i + 1) % NCH, tv_dvd[i], tv_dsr[i], tv_q[i], tv_dbz[i], tv_ovf[i]);
            wait_grants(1);
            wait_idle();
        end

        // Backpressure with a second request waiting behind the stalled response.
        rsp_ready = 1'b0;
        post(3, 32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0);
        wait_grants(1);
        post(1, 32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);
        for (int b = 0; b < 200 && !rsp_valid; b++) begin
            @(posedge clk);
            #1;
        end
        if (!rsp_valid) fail("rsp_valid_timeout");
        repeat (20) @(posedge clk);
        #1;
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_no_grant", req_ready, 0);
        rsp_ready = 1'b1;
        hs = cyc + 1;
        wait_grants(1);
        if (acc_q.size() != 0) chk("reissue_gap", acc_q[$] - hs, 1);
        else fail("reissue_gap");
        wait_idle();

        // Reset in the middle of a division.
        post(2, 32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        wait_grants(1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_rst();
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid || busy) stray++;
        end
        chk("no_rsp_after_reset", stray, 0);
        @(posedge clk);
        #1;

        // Pointer restarts at 0: ch1 wins over ch3.
        post(1, 32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0);
        post(3, 32'hFFFB0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
        wait_grants(2);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
